// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester, FIFO-write and credit signals around the write arbiter.
// The master modport is the arbiter side; the slave modport is the requesters/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NREQ_LOG = 2,
  parameter int unsigned LEN_LOG  = 2
);
  localparam int unsigned NREQ = 1 << NREQ_LOG;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               enq;
  logic [DW-1:0]      din;
  logic [NREQ_LOG-1:0] dtag;
  logic               credit_ret;
  logic [LEN_LOG:0]   credit;
  logic               busy;
  logic               ovf_err;

  modport master (
    input  req_valid, req_last, req_data, credit_ret,
    output req_ready, enq, din, dtag, credit, busy, ovf_err
  );

  modport slave (
    output req_valid, req_last, req_data, credit_ret,
    input  req_ready, enq, din, dtag, credit, busy, ovf_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Credit-based round-robin arbiter sharing one FIFO write port among NREQ requesters.
// A grant holds for up to BURST beats so a requester's beats stay contiguous in the FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NREQ_LOG = 2,
  parameter int unsigned LEN_LOG  = 2,
  parameter int unsigned BURST    = 4
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic                SRST,
  fifo_wr_arbiter_if.master   bus
);
  localparam int unsigned NREQ = 1 << NREQ_LOG;
  localparam int unsigned LEN  = 1 << LEN_LOG;
  localparam logic [LEN_LOG:0] CreditFull = (LEN_LOG+1)'(LEN);
  localparam logic [7:0]       LastBeat   = 8'(BURST - 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e              r_state, w_state_d;
  logic [NREQ_LOG-1:0] r_ptr, w_ptr_d;
  logic [NREQ_LOG-1:0] r_g, w_g_d;
  logic [7:0]          r_beat, w_beat_d;
  logic [LEN_LOG:0]    r_credit, w_credit_d;
  logic                r_ovf, w_ovf_d;

  logic                w_found;
  logic [NREQ_LOG-1:0] w_pick;
  logic [NREQ_LOG-1:0] w_idx;
  logic                w_has_credit;
  logic                w_xfer;
  logic                w_enq;

  assign w_has_credit = (r_credit != '0);
  assign w_xfer = (r_state == StBurst) && bus.req_valid[r_g] && w_has_credit;
  // A synchronous clear cancels the beat so nothing is written or accepted that cycle.
  assign w_enq  = w_xfer && !SRST;

  // Rotating priority scan: first valid requester starting at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = r_ptr + NREQ_LOG'(i);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Next-state logic for the grant FSM, pointer and beat counter.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_g_d     = r_g;
    w_beat_d  = r_beat;
    unique case (r_state)
      StIdle: begin
        if (w_found && w_has_credit) begin
          w_state_d = StBurst;
          w_g_d     = w_pick;
          w_beat_d  = '0;
        end
      end
      StBurst: begin
        if (!bus.req_valid[r_g]) begin
          w_state_d = StIdle;
          w_ptr_d   = r_g + 1'b1;
        end else if (w_has_credit) begin
          w_beat_d = r_beat + 8'd1;
          if (bus.req_last[r_g] || (r_beat == LastBeat)) begin
            w_state_d = StIdle;
            w_ptr_d   = r_g + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Credit accounting; a return at full credit is an upstream error and is latched.
  always_comb begin
    w_credit_d = r_credit;
    w_ovf_d    = r_ovf;
    if (w_enq && !bus.credit_ret) begin
      w_credit_d = r_credit - 1'b1;
    end else if (!w_enq && bus.credit_ret) begin
      if (r_credit == CreditFull) begin
        w_ovf_d = 1'b1;
      end else begin
        w_credit_d = r_credit + 1'b1;
      end
    end
  end

  // State registers: async reset and sync clear share the same reset values.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_g      <= '0;
      r_beat   <= '0;
      r_credit <= CreditFull;
      r_ovf    <= 1'b0;
    end else if (SRST) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_g      <= '0;
      r_beat   <= '0;
      r_credit <= CreditFull;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_ptr    <= w_ptr_d;
      r_g      <= w_g_d;
      r_beat   <= w_beat_d;
      r_credit <= w_credit_d;
      r_ovf    <= w_ovf_d;
    end
  end

  // Output drive: only the granted requester may see ready, and only on a real transfer.
  always_comb begin
    bus.req_ready      = '0;
    bus.req_ready[r_g] = w_enq;
    bus.enq            = w_enq;
    bus.din            = bus.req_data[r_g*DW +: DW];
    bus.dtag           = r_g;
    bus.credit         = r_credit;
    bus.busy           = (r_state == StBurst);
    bus.ovf_err        = r_ovf;
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DW=32, 4 requesters, FIFO depth 4, BURST 4).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_fifo_wr_arbiter;
  logic CLK;
  logic RST_X;
  logic SRST;
  int   n_run;
  int   n_fail;

  fifo_wr_arbiter_if #(.DW(32), .NREQ_LOG(2), .LEN_LOG(2)) bus ();

  fifo_wr_arbiter #(.DW(32), .NREQ_LOG(2), .LEN_LOG(2), .BURST(4)) u_dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .SRST  (SRST),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_srst;
    nxt();
    SRST = 1'b1;
    nxt();
    SRST = 1'b0;
  endtask

  task automatic test_reset;
    RST_X = 1'b0;
    SRST  = 1'b0;
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    bus.credit_ret = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_run++; if (bus.enq !== 1'b0) begin n_fail++;
      $display("FAIL reset_enq got %b exp 0", bus.enq); end
    n_run++; if (bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_run++; if (bus.credit !== 3'd4) begin n_fail++;
      $display("FAIL reset_credit got %0d exp 4", bus.credit); end
    n_run++; if (bus.ovf_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_ovf got %b exp 0", bus.ovf_err); end
    RST_X = 1'b1;
  endtask

  task automatic test_single;
    logic [31:0] exp_d;
    nxt();
    bus.req_valid = 4'b0010;
    bus.req_data[32 +: 32] = 32'hA0;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b0) begin n_fail++;
      $display("FAIL single_idle_enq got %b exp 0", bus.enq); end
    for (int b = 0; b < 3; b++) begin
      nxt();
      exp_d = 32'hA0 + 32'(b);
      bus.req_data[32 +: 32] = exp_d;
      bus.req_last[1] = (b == 2);
      @(negedge CLK);
      n_run++; if (bus.enq !== 1'b1) begin n_fail++;
        $display("FAIL single_enq%0d got %b exp 1", b, bus.enq); end
      n_run++; if (bus.dtag !== 2'd1) begin n_fail++;
        $display("FAIL single_dtag%0d got %0d exp 1", b, bus.dtag); end
      n_run++; if (bus.din !== exp_d) begin n_fail++;
        $display("FAIL single_din%0d got %h exp %h", b, bus.din, exp_d); end
      n_run++; if (bus.req_ready !== 4'b0010) begin n_fail++;
        $display("FAIL single_ready%0d got %b exp 0010", b, bus.req_ready); end
    end
    nxt();
    bus.req_valid = '0;
    bus.req_last  = '0;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b0) begin n_fail++;
      $display("FAIL single_after_enq got %b exp 0", bus.enq); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL single_after_busy got %b exp 0", bus.busy); end
    n_run++; if (bus.credit !== 3'd1) begin n_fail++;
      $display("FAIL single_credit got %0d exp 1", bus.credit); end
    nxt();
    bus.credit_ret = 1'b1;
    repeat (3) nxt();
    bus.credit_ret = 1'b0;
    @(negedge CLK);
    n_run++; if (bus.credit !== 3'd4) begin n_fail++;
      $display("FAIL single_refill got %0d exp 4", bus.credit); end
  endtask

  task automatic test_round_robin;
    logic       exp_enq;
    logic [1:0] exp_tag;
    do_srst();
    bus.req_valid  = 4'b0111;
    bus.req_last   = '0;
    bus.credit_ret = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) nxt();
      @(negedge CLK);
      exp_enq = ((c % 5) != 0);
      exp_tag = 2'((c / 5) % 3);
      n_run++; if (bus.enq !== exp_enq) begin n_fail++;
        $display("FAIL rr_enq c%0d got %b exp %b", c, bus.enq, exp_enq); end
      if (exp_enq) begin
        n_run++; if (bus.dtag !== exp_tag) begin n_fail++;
          $display("FAIL rr_tag c%0d got %0d exp %0d", c, bus.dtag, exp_tag); end
      end
    end
    n_run++; if (bus.credit !== 3'd4) begin n_fail++;
      $display("FAIL rr_credit got %0d exp 4", bus.credit); end
    n_run++; if (bus.ovf_err !== 1'b1) begin n_fail++;
      $display("FAIL rr_ovf got %b exp 1", bus.ovf_err); end
    nxt();
    bus.req_valid  = '0;
    bus.credit_ret = 1'b0;
  endtask

  task automatic test_stall;
    do_srst();
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_data[0 +: 32] = 32'hB0;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b0) begin n_fail++;
      $display("FAIL stall_idle0 got %b exp 0", bus.enq); end
    nxt();
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b1) begin n_fail++;
      $display("FAIL stall_first got %b exp 1", bus.enq); end
    nxt();
    bus.req_last = '0;
    bus.req_data[0 +: 32] = 32'hB1;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL stall_rearb got enq=%b busy=%b exp 0 0", bus.enq, bus.busy); end
    for (int b = 0; b < 3; b++) begin
      nxt();
      @(negedge CLK);
      n_run++; if (bus.enq !== 1'b1) begin n_fail++;
        $display("FAIL stall_beat%0d got %b exp 1", b, bus.enq); end
    end
    for (int s = 0; s < 2; s++) begin
      nxt();
      bus.credit_ret = (s == 1);
      @(negedge CLK);
      n_run++; if (bus.enq !== 1'b0 || bus.busy !== 1'b1) begin n_fail++;
        $display("FAIL stall_hold%0d got enq=%b busy=%b exp 0 1", s, bus.enq, bus.busy); end
      n_run++; if (bus.credit !== 3'd0 || bus.req_ready !== 4'b0000) begin n_fail++;
        $display("FAIL stall_cr%0d got credit=%0d ready=%b exp 0 0000", s, bus.credit,
                 bus.req_ready); end
    end
    nxt();
    bus.credit_ret = 1'b0;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b1 || bus.credit !== 3'd1) begin n_fail++;
      $display("FAIL stall_release got enq=%b credit=%0d exp 1 1", bus.enq, bus.credit); end
    for (int s = 0; s < 2; s++) begin
      nxt();
      @(negedge CLK);
      n_run++; if (bus.enq !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
        $display("FAIL stall_after%0d got enq=%b busy=%b exp 0 0", s, bus.enq, bus.busy); end
    end
    n_run++; if (bus.credit !== 3'd0) begin n_fail++;
      $display("FAIL stall_empty got %0d exp 0", bus.credit); end
    bus.req_valid = '0;
  endtask

  task automatic test_credit;
    nxt();
    bus.credit_ret = 1'b1;
    repeat (2) nxt();
    bus.credit_ret = 1'b0;
    bus.req_valid  = 4'b0100;
    bus.req_last   = 4'b0100;
    bus.req_data[64 +: 32] = 32'hC0;
    @(negedge CLK);
    n_run++; if (bus.credit !== 3'd2) begin n_fail++;
      $display("FAIL credit_two got %0d exp 2", bus.credit); end
    nxt();
    bus.credit_ret = 1'b1;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b1 || bus.din !== 32'hC0) begin n_fail++;
      $display("FAIL credit_beat got enq=%b din=%h exp 1 c0", bus.enq, bus.din); end
    nxt();
    bus.credit_ret = 1'b0;
    bus.req_valid  = '0;
    bus.req_last   = '0;
    @(negedge CLK);
    n_run++; if (bus.credit !== 3'd2) begin n_fail++;
      $display("FAIL credit_same got %0d exp 2", bus.credit); end
    bus.credit_ret = 1'b1;
    repeat (2) nxt();
    bus.credit_ret = 1'b0;
    @(negedge CLK);
    n_run++; if (bus.credit !== 3'd4 || bus.ovf_err !== 1'b0) begin n_fail++;
      $display("FAIL credit_full got credit=%0d ovf=%b exp 4 0", bus.credit, bus.ovf_err); end
    nxt();
    bus.credit_ret = 1'b1;
    nxt();
    bus.credit_ret = 1'b0;
    @(negedge CLK);
    n_run++; if (bus.credit !== 3'd4 || bus.ovf_err !== 1'b1) begin n_fail++;
      $display("FAIL credit_ovf got credit=%0d ovf=%b exp 4 1", bus.credit, bus.ovf_err); end
    repeat (2) nxt();
    @(negedge CLK);
    n_run++; if (bus.ovf_err !== 1'b1) begin n_fail++;
      $display("FAIL credit_ovf_sticky got %b exp 1", bus.ovf_err); end
    do_srst();
    @(negedge CLK);
    n_run++; if (bus.ovf_err !== 1'b0 || bus.credit !== 3'd4) begin n_fail++;
      $display("FAIL credit_srst got ovf=%b credit=%0d exp 0 4", bus.ovf_err, bus.credit); end
  endtask

  task automatic test_withdraw;
    do_srst();
    bus.req_valid = 4'b1000;
    bus.req_last  = '0;
    bus.req_data[96 +: 32] = 32'hD0;
    @(negedge CLK);
    for (int b = 0; b < 2; b++) begin
      nxt();
      @(negedge CLK);
      n_run++; if (bus.enq !== 1'b1 || bus.dtag !== 2'd3) begin n_fail++;
        $display("FAIL wd_beat%0d got enq=%b tag=%0d exp 1 3", b, bus.enq, bus.dtag); end
    end
    nxt();
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_data[0 +: 32] = 32'hE0;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b0 || bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL wd_drop got enq=%b ready=%b exp 0 0000", bus.enq, bus.req_ready); end
    nxt();
    @(negedge CLK);
    n_run++; if (bus.busy !== 1'b0 || bus.enq !== 1'b0) begin n_fail++;
      $display("FAIL wd_idle got busy=%b enq=%b exp 0 0", bus.busy, bus.enq); end
    nxt();
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b1 || bus.dtag !== 2'd0 || bus.din !== 32'hE0) begin n_fail++;
      $display("FAIL wd_next got enq=%b tag=%0d din=%h exp 1 0 e0", bus.enq, bus.dtag,
               bus.din); end
    nxt();
    bus.req_valid = '0;
    bus.req_last  = '0;
    @(negedge CLK);
    n_run++; if (bus.credit !== 3'd1) begin n_fail++;
      $display("FAIL wd_credit got %0d exp 1", bus.credit); end
  endtask

  task automatic test_srst_burst;
    do_srst();
    bus.req_valid = 4'b0010;
    bus.req_last  = '0;
    @(negedge CLK);
    nxt();
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b1 || bus.dtag !== 2'd1) begin n_fail++;
      $display("FAIL srst_pre got enq=%b tag=%0d exp 1 1", bus.enq, bus.dtag); end
    nxt();
    SRST = 1'b1;
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b0 || bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL srst_enq got enq=%b ready=%b exp 0 0000", bus.enq, bus.req_ready); end
    nxt();
    SRST = 1'b0;
    bus.req_valid = 4'b0110;
    @(negedge CLK);
    n_run++; if (bus.busy !== 1'b0 || bus.credit !== 3'd4 || bus.enq !== 1'b0) begin
      n_fail++;
      $display("FAIL srst_after got busy=%b credit=%0d enq=%b exp 0 4 0", bus.busy,
               bus.credit, bus.enq); end
    nxt();
    @(negedge CLK);
    n_run++; if (bus.enq !== 1'b1 || bus.dtag !== 2'd1) begin n_fail++;
      $display("FAIL srst_ptr got enq=%b tag=%0d exp 1 1", bus.enq, bus.dtag); end
    RST_X = 1'b0;
    #1;
    n_run++; if (bus.enq !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL arst_outputs got enq=%b busy=%b ready=%b exp 0 0 0000", bus.enq,
               bus.busy, bus.req_ready); end
    n_run++; if (bus.credit !== 3'd4 || bus.ovf_err !== 1'b0) begin n_fail++;
      $display("FAIL arst_credit got credit=%0d ovf=%b exp 4 0", bus.credit, bus.ovf_err); end
    bus.req_valid = '0;
    nxt();
    RST_X = 1'b1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_credit();
    test_withdraw();
    test_srst_burst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Single-clock, credit-based round-robin arbiter that shares the write port of a register FIFO among NREQ requesters.
- Sits on the FIFO write-clock side and drives enq/din directly.
- Tracks free FIFO slots by counting its own enq pulses against credit_ret pulses; each credit_ret pulse marks one slot freed on the read side, already synchronised into CLK upstream.
- Grants bursts of up to BURST beats so that beats from one requester stay contiguous.

Parameters:
- DW, 32, data width.
- NREQ_LOG, 2, log2 of the requester count.
- NREQ, 1 << NREQ_LOG, requester count.
- LEN_LOG, 2, log2 of the downstream FIFO depth.
- LEN, 1 << LEN_LOG, FIFO depth; also the initial credit.
- BURST, 4, maximum beats per grant (1..255).

Ports:
- CLK  in  1  clock.
- RST_X  in  1  asynchronous active-low reset.
- SRST  in  1  synchronous clear, active-high.
- req_valid  in  NREQ  per-requester data valid.
- req_last  in  NREQ  per-requester end-of-packet marker, qualified by valid.
- req_data  in  NREQ*DW  flattened data; requester i occupies [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept; a beat transfers when valid && ready.
- enq  out  1  FIFO write strobe.
- din  out  DW  FIFO write data.
- dtag  out  NREQ_LOG  index of the requester owning the current beat.
- credit_ret  in  1  one FIFO slot freed (single-cycle pulse).
- credit  out  LEN_LOG+1  free-slot count.
- busy  out  1  a grant is held.
- ovf_err  out  1  sticky; credit return seen while credit == LEN.

Behaviour:
- Reset (RST_X low, asynchronous) and SRST (synchronous) both force:
  - state = IDLE, ptr = 0, grant index g = 0, beat counter = 0
  - credit = LEN, ovf_err = 0, enq = 0, req_ready = 0
- SRST wins over all same-cycle events: enq is suppressed and credit_ret is ignored in that cycle.
- State machine, states IDLE and BURST.
- IDLE:
  - enq = 0, req_ready = 0.
  - If any req_valid is set and credit != 0: pick the first valid requester scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - Register it into g, clear the beat counter, go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - xfer = req_valid[g] && (credit != 0). This is combinational from the registered g and credit.
  - req_ready[g] = xfer; all other req_ready bits = 0.
  - enq = xfer; din = req_data[g]; dtag = g.
  - Each xfer increments the beat counter.
  - Release the grant (go to IDLE, ptr <= g+1 mod NREQ) on any of:
    - an xfer with req_last[g] set;
    - an xfer that is beat number BURST;
    - req_valid[g] low (requester withdrew). This releases with no transfer that cycle.
  - credit == 0 with req_valid[g] high: stall. Hold the grant and beat count, enq = 0, no release.
- Latency and throughput:
  - A request in IDLE at cycle n gives its first enq at cycle n+1.
  - Back-to-back beats follow at one per cycle while credit remains.
  - Re-arbitration costs one IDLE cycle between grants.
- Credit update, next credit = credit - enq + credit_ret:
  - enq and credit_ret in the same cycle leave credit unchanged.
  - credit_ret with credit == LEN and no enq: credit stays at LEN and ovf_err sets. ovf_err clears only on reset or SRST.
  - enq can never occur at credit == 0, so credit never underflows.
- busy = (state == BURST).
- Fairness: after requester g is served, it has the lowest priority at the next arbitration.
- All outputs are driven from registered state plus the listed combinational terms. There is no combinational path from credit_ret to enq.

Test Plan:
- Reset, then requester 1 alone sends 3 beats 0xA0..0xA2 with last on the third. Required: enq high for exactly cycles 1..3 after the request, dtag = 1 on each beat, credit 4 -> 1, then state returns to IDLE.
- Requesters 0, 1 and 2 all valid with long packets, BURST = 4, LEN = 16, credit_ret pulsed every cycle. Required: grant order 0, 1, 2, 0, exactly 4 beats per grant, one idle cycle between grants.
- LEN = 4, requester 0 sends 6 beats with no returns. Required: 4 enq pulses, then credit = 0 and a stall with busy held. A single credit_ret pulse must release exactly one more beat on the next cycle.
- enq and credit_ret in the same cycle at credit = 2. Required: credit stays 2. A credit_ret at credit = LEN sets ovf_err = 1, and ovf_err holds until SRST.
- Requester 3 drops valid mid-burst after 2 beats. Required: grant released, ptr = 0, next winner is requester 0 if it is valid.
- SRST asserted during a BURST beat. Required: no enq that cycle, and next cycle shows state IDLE, credit = LEN, ptr = 0. Asynchronous RST_X low mid-burst clears all outputs immediately.
